interrupt_request_latch: RTL
============================

// Module: interrupt_request_latch
// PURPOSE
//   Upstream stage of the 8-line priority encoder. Captures raw interrupt lines, per line
//   edge- or level-sensitive, and holds them in a pending register. Presents the masked
//   vector d[7:0] to the encoder. Raises a registered int_req, then runs the ack / end-of-
//   interrupt handshake using the encoder's 3-bit code {x,y,z} fed back as ack_code.
// PARAMETERS
//   N         8     request lines; fixed at 8 to match the encoder, others unsupported
//   CODE_W    3     width of ack_code/svc_code, log2(N)
// PORTS
//   clk         input   1  single clock; all state updates on posedge
//   rst_b       input   1  asynchronous, active-low reset
//   irq_in      input   8  raw request lines
//   level_mode  input   8  per line: 1 = level-sensitive, 0 = rising-edge
//   mask        input   8  per line: 1 = enabled to encoder, 0 = hidden (still latched)
//   ack         input   1  1-cycle acknowledge from the consumer
//   ack_code    input   3  index being acknowledged (encoder {x,y,z})
//   eoi         input   1  1-cycle end-of-interrupt
//   d           output  8  pending & mask; drives encoder d[7:0]
//   int_req     output  1  registered interrupt request to the consumer
//   busy        output  1  1 while in SERVICE
//   svc_code    output  3  index latched at the accepted ack
// BEHAVIOUR
//   Reset (async, rst_b=0): pending=0, prev_irq=8'hFF, state=IDLE, int_req=0, busy=0,
//     svc_code=0, so d=0. A line already high when reset releases is NOT an edge.
//   Capture, each cycle, for each line i:
//     - set_i = level_mode[i] ? irq_in[i] : (irq_in[i] & ~prev_irq[i]).
//     - prev_irq <= irq_in.
//     - Lines latch regardless of mask.
//   Latency:
//     - irq_in rises before edge n -> pending and d set after edge n.
//     - int_req is 1 after edge n+1.
//   d = pending & mask. d is combinational from flops, so a mask change shows the same cycle.
//   FSM (IDLE, PENDING, SERVICE):
//     IDLE:    |d -> PENDING with int_req<=1. Otherwise stay.
//     PENDING: ack & d[ack_code] -> SERVICE.
//                - clear pending[ack_code]
//                - svc_code<=ack_code, int_req<=0, busy<=1
//              ack & ~d[ack_code] -> spurious. Ignored: no clear, stay in PENDING.
//              ~ack & d==0 (masked or withdrawn) -> IDLE with int_req<=0.
//     SERVICE: eoi -> IDLE with busy<=0. New requests keep latching. int_req stays 0.
//   ack outside PENDING and eoi outside SERVICE are ignored.
//   ack and eoi in the same cycle: only the input valid for the current state acts.
//   Set and clear of the same bit in one cycle: set wins.
//     - A new edge is never lost.
//     - A held level line re-pends immediately.
//   Reset asserted mid-handshake: immediate return to reset values. Any pending request is dropped.
// CONFIGURATION
//   IRQ_SYNC_EN defined:
//     - irq_in passes through a 2-flop synchroniser (reset 0) before capture.
//     - Capture latency grows by 2 cycles; d settles after edge n+2, int_req after edge n+3.
//     - Edge detection is done on the synchronised signal.
//   IRQ_SYNC_EN undefined: irq_in is assumed synchronous to clk and sampled directly.
// STRUCTURE
//   Shared header irq_defs.vh holds:
//     - the FSM state encodings IRQ_IDLE=2'd0, IRQ_PENDING=2'd1, IRQ_SERVICE=2'd2
//     - IRQ_N=8 and IRQ_CODE_W=3
//   One natural sub-module, irq_edge_capture: the per-line sync (optional), prev flop,
//     edge/level select, and the pending bit with set-wins clear.
//   The top level holds the FSM, the output registers and the d masking.
// TESTING
//   1. Reset with irq_in=8'h01 held -> pending=0, d=0, int_req=0 (no edge). Level_mode[0]=1
//      -> d=8'h01 next cycle.
//   2. Edge mode: pulse irq_in[5] for 1 cycle, mask=8'hFF -> d=8'h20, int_req=1 one cycle
//      later. ack with ack_code=5 -> d=0, busy=1, svc_code=5. eoi -> busy=0, state IDLE.
//   3. Lines 2 and 6 pending, ack_code=3 -> spurious: d stays 8'h44, int_req stays 1.
//      Then ack_code=6 -> d=8'h04.
//   4. In PENDING with d=8'h10, set mask=8'h00 -> d=0 the same cycle, int_req=0 next cycle.
//      Restore mask -> int_req=1 again.
//   5. New edge on line 3 on the same cycle as ack_code=3 -> pending[3] stays 1.
//      After eoi, FSM re-enters PENDING.
//   6. Drop rst_b mid-SERVICE -> all outputs go to reset values asynchronously.
//      With IRQ_SYNC_EN defined, repeat test 2 and check int_req 2 cycles later.

Source files
------------

// File: rtl/interrupt_request_latch_pkg.sv
// Shared definitions for the interrupt request latch: line count, code width, FSM states.
package interrupt_request_latch_pkg;

    localparam int unsigned IRQ_N      = 8;
    localparam int unsigned IRQ_CODE_W = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // One-hot select of the line addressed by an encoder code.
    function automatic logic [IRQ_N-1:0] code_to_onehot(input logic [IRQ_CODE_W-1:0] code);
        return IRQ_N'(1) << code;
    endfunction

endpackage

// File: rtl/interrupt_request_latch_irq_edge_capture.sv
// Per-line capture: optional 2-flop synchroniser (IRQ_SYNC_EN), edge/level select,
// and the pending register where a same-cycle set overrides a clear.
module interrupt_request_latch_irq_edge_capture
    import interrupt_request_latch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [IRQ_N-1:0]     irq_in,
    input  logic [IRQ_N-1:0]     level_mode,
    input  logic [IRQ_N-1:0]     clr,
    output logic [IRQ_N-1:0]     pending
);

    logic [IRQ_N-1:0] irq_s;
    logic [IRQ_N-1:0] prev_irq_d, prev_irq_q;
    logic [IRQ_N-1:0] pending_d, pending_q;
    logic [IRQ_N-1:0] set_c;

`ifdef IRQ_SYNC_EN
    logic [IRQ_N-1:0] sync1_d, sync1_q;
    logic [IRQ_N-1:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // Reset prev to all ones so a line already high at reset release is not an edge.
    always_comb begin
        set_c      = (level_mode & irq_s) | (~level_mode & irq_s & ~prev_irq_q);
        prev_irq_d = irq_s;
        pending_d  = (pending_q & ~clr) | set_c;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prev_irq_q <= '1;
            pending_q  <= '0;
        end else begin
            prev_irq_q <= prev_irq_d;
            pending_q  <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/interrupt_request_latch.sv
// Interrupt request latch: captures lines, presents masked vector d to the encoder,
// and runs the int_req / ack / eoi handshake. Optional input synchroniser: IRQ_SYNC_EN.
module interrupt_request_latch
    import interrupt_request_latch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic [7:0]              irq_in,
    input  logic [7:0]              level_mode,
    input  logic [7:0]              mask,
    input  logic                    ack,
    input  logic [2:0]              ack_code,
    input  logic                    eoi,
    output logic [7:0]              d,
    output logic                    int_req,
    output logic                    busy,
    output logic [2:0]              svc_code
);

    irq_state_e              state_d, state_q;
    logic                    int_req_d, int_req_q;
    logic                    busy_d, busy_q;
    logic [IRQ_CODE_W-1:0]   svc_code_d, svc_code_q;
    logic [IRQ_N-1:0]        clr_c;
    logic [IRQ_N-1:0]        pending;

    interrupt_request_latch_irq_edge_capture u_capture (
        .clk        (clk),
        .rst_b      (rst_b),
        .irq_in     (irq_in),
        .level_mode (level_mode),
        .clr        (clr_c),
        .pending    (pending)
    );

    assign d = pending & mask;

    always_comb begin
        state_d    = state_q;
        int_req_d  = int_req_q;
        busy_d     = busy_q;
        svc_code_d = svc_code_q;
        clr_c      = '0;
        case (state_q)
            IRQ_IDLE: begin
                if (|d) begin
                    state_d   = IRQ_PENDING;
                    int_req_d = 1'b1;
                end
            end
            IRQ_PENDING: begin
                // An ack naming a line that is not visible is spurious and ignored.
                if (ack && d[ack_code]) begin
                    state_d    = IRQ_SERVICE;
                    clr_c      = code_to_onehot(ack_code);
                    svc_code_d = ack_code;
                    int_req_d  = 1'b0;
                    busy_d     = 1'b1;
                end else if (!ack && (d == '0)) begin
                    state_d   = IRQ_IDLE;
                    int_req_d = 1'b0;
                end
            end
            IRQ_SERVICE: begin
                if (eoi) begin
                    state_d = IRQ_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IRQ_IDLE;
                int_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IRQ_IDLE;
            int_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            svc_code_q <= '0;
        end else begin
            state_q    <= state_d;
            int_req_q  <= int_req_d;
            busy_q     <= busy_d;
            svc_code_q <= svc_code_d;
        end
    end

    assign int_req  = int_req_q;
    assign busy     = busy_q;
    assign svc_code = svc_code_q;

endmodule
